// File: rtl/dmem_access_unit_pkg.sv
// Shared definitions for the data-memory access unit: size encodings and FSM states.
package dmem_access_unit_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BAD  = 2'b10;
  localparam logic [1:0] SZ_WORD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESP
  } state_t;

endpackage

// File: rtl/dmem_access_unit_load_extend.sv
// Load extension: picks the leading byte/halfword/word of a big-endian memory read and
// zero- or sign-extends it; shared with the writeback stage.
module dmem_access_unit_load_extend
  import dmem_access_unit_pkg::*;
(
  input  logic [0:31] i_rdata,
  input  logic [0:1]  i_size,
  input  logic        i_signed,
  output logic [0:31] o_result
);

  always_comb begin
    o_result = i_rdata;
    case (i_size)
      SZ_BYTE: o_result = {{24{i_signed & i_rdata[0]}}, i_rdata[0:7]};
      SZ_HALF: o_result = {{16{i_signed & i_rdata[0]}}, i_rdata[0:15]};
      default: o_result = i_rdata;
    endcase
  end

endmodule

// File: rtl/dmem_access_unit.sv
// MEM-stage master for the data memory port: one request at a time, alignment/size checks,
// registered response. Optional address bounds check enabled by `define DMEM_BOUNDS_CHECK_EN.
module dmem_access_unit
  import dmem_access_unit_pkg::*;
#(
  parameter int unsigned DMEM_SIZE = 32768
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [0:31] i_req_addr,
  input  logic [0:31] i_req_wdata,
  input  logic        i_req_we,
  input  logic [0:1]  i_req_size,
  input  logic        i_req_signed,
  output logic        o_resp_valid,
  input  logic        i_resp_ready,
  output logic [0:31] o_resp_rdata,
  output logic        o_resp_err,
  output logic [0:31] o_mem_addr,
  output logic [0:31] o_mem_wData,
  output logic        o_mem_writeEnable,
  output logic [0:1]  o_mem_dsize,
  input  logic [0:31] i_mem_rData
);

  state_t      r_state;
  state_t      w_nextState;
  logic [0:31] r_addr;
  logic [0:31] r_wdata;
  logic [0:1]  r_size;
  logic        r_we;
  logic        r_signed;
  logic [0:31] r_rdata;
  logic        r_err;

  logic        w_accept;
  logic        w_misaligned;
  logic        w_oob;
  logic        w_reqErr;
  logic [0:31] w_loadData;

  // A memory smaller than one word cannot hold any aligned word access.
  if (DMEM_SIZE < 4) begin : g_sizeCheck
    $error("dmem_access_unit: DMEM_SIZE must be at least 4 bytes");
  end

  assign w_accept     = i_req_valid & o_req_ready;
  assign w_misaligned = ((i_req_size == SZ_HALF) && i_req_addr[31]) ||
                        ((i_req_size == SZ_WORD) && (i_req_addr[30:31] != 2'b00));

`ifdef DMEM_BOUNDS_CHECK_EN
  // 33-bit end address so a request near 0xFFFFFFFF cannot wrap back into range.
  logic [32:0] w_endAddr;
  assign w_endAddr = {1'b0, i_req_addr} + {31'b0, i_req_size} + 33'd1;
  assign w_oob     = w_endAddr > {1'b0, DMEM_SIZE};
`else
  assign w_oob = 1'b0;
`endif

  assign w_reqErr = (i_req_size == SZ_BAD) || w_misaligned || w_oob;

  dmem_access_unit_load_extend u_loadExtend (
    .i_rdata  (i_mem_rData),
    .i_size   (r_size),
    .i_signed (r_signed),
    .o_result (w_loadData)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Handshake outputs are gated by reset so a store in flight cannot write at the next edge.
  always_comb begin
    w_nextState       = r_state;
    o_req_ready       = 1'b0;
    o_resp_valid      = 1'b0;
    o_mem_writeEnable = 1'b0;
    case (r_state)
      ST_IDLE: begin
        o_req_ready = i_rst_n;
        if (w_accept) begin
          w_nextState = w_reqErr ? ST_RESP : ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        o_mem_writeEnable = i_rst_n & r_we;
        w_nextState       = ST_RESP;
      end
      ST_RESP: begin
        o_resp_valid = 1'b1;
        if (i_resp_ready) begin
          w_nextState = ST_IDLE;
        end
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  // Request fields only latch for legal requests, so the memory bus holds its last access.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_addr   <= '0;
      r_wdata  <= '0;
      r_size   <= SZ_BYTE;
      r_we     <= 1'b0;
      r_signed <= 1'b0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_accept && !w_reqErr) begin
        r_addr   <= i_req_addr;
        r_wdata  <= i_req_wdata;
        r_size   <= i_req_size;
        r_we     <= i_req_we;
        r_signed <= i_req_signed;
      end
      if (w_accept && w_reqErr) begin
        r_rdata <= '0;
        r_err   <= 1'b1;
      end
      if (r_state == ST_ACCESS) begin
        r_rdata <= r_we ? '0 : w_loadData;
        r_err   <= 1'b0;
      end
    end
  end

  assign o_resp_rdata = r_rdata;
  assign o_resp_err   = r_err;
  assign o_mem_addr   = r_addr;
  assign o_mem_wData  = r_wdata;
  assign o_mem_dsize  = r_size;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Self-checking bench for dmem_access_unit: directed cases plus randomized traffic against
// a byte-array reference model; also honours `define DMEM_BOUNDS_CHECK_EN.
module tb_dmem_access_unit;

  localparam int unsigned BENCH_DMEM = 16384;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_req_valid;
  logic        o_req_ready;
  logic [0:31] i_req_addr;
  logic [0:31] i_req_wdata;
  logic        i_req_we;
  logic [0:1]  i_req_size;
  logic        i_req_signed;
  logic        o_resp_valid;
  logic        i_resp_ready;
  logic [0:31] o_resp_rdata;
  logic        o_resp_err;
  logic [0:31] o_mem_addr;
  logic [0:31] o_mem_wData;
  logic        o_mem_writeEnable;
  logic [0:1]  o_mem_dsize;
  logic [0:31] i_mem_rData;

  int checks = 0;
  int errors = 0;

  // Memory the DUT talks to, and the transaction-level reference copy.
  logic [7:0] simMem [0:32767];
  logic [7:0] refMem [0:32767];

  dmem_access_unit #(.DMEM_SIZE(BENCH_DMEM)) dut (
    .i_clk             (i_clk),
    .i_rst_n           (i_rst_n),
    .i_req_valid       (i_req_valid),
    .o_req_ready       (o_req_ready),
    .i_req_addr        (i_req_addr),
    .i_req_wdata       (i_req_wdata),
    .i_req_we          (i_req_we),
    .i_req_size        (i_req_size),
    .i_req_signed      (i_req_signed),
    .o_resp_valid      (o_resp_valid),
    .i_resp_ready      (i_resp_ready),
    .o_resp_rdata      (o_resp_rdata),
    .o_resp_err        (o_resp_err),
    .o_mem_addr        (o_mem_addr),
    .o_mem_wData       (o_mem_wData),
    .o_mem_writeEnable (o_mem_writeEnable),
    .o_mem_dsize       (o_mem_dsize),
    .i_mem_rData       (i_mem_rData)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Combinational big-endian read of addr..addr+3.
  logic [31:0] memAddrVal;
  logic [31:0] memWDataVal;
  logic [14:0] memIdx;
  assign memAddrVal  = o_mem_addr;
  assign memWDataVal = o_mem_wData;
  assign memIdx      = memAddrVal[14:0];
  assign i_mem_rData = {simMem[memIdx], simMem[memIdx + 15'd1],
                        simMem[memIdx + 15'd2], simMem[memIdx + 15'd3]};

  // Memory write lanes take right-justified data.
  always @(posedge i_clk) begin
    if (o_mem_writeEnable) begin
      case (o_mem_dsize)
        2'b00: simMem[memIdx] = memWDataVal[7:0];
        2'b01: begin
          simMem[memIdx]         = memWDataVal[15:8];
          simMem[memIdx + 15'd1] = memWDataVal[7:0];
        end
        default: begin
          simMem[memIdx]         = memWDataVal[31:24];
          simMem[memIdx + 15'd1] = memWDataVal[23:16];
          simMem[memIdx + 15'd2] = memWDataVal[15:8];
          simMem[memIdx + 15'd3] = memWDataVal[7:0];
        end
      endcase
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic int sizeBytes(input int size);
    return (size == 0) ? 1 : (size == 1) ? 2 : 4;
  endfunction

  function automatic logic refError(input int addr, input int size);
    logic err;
    err = (size == 2) || ((addr % sizeBytes(size)) != 0);
`ifdef DMEM_BOUNDS_CHECK_EN
    if (longint'(addr) + longint'(sizeBytes(size)) > longint'(BENCH_DMEM)) err = 1'b1;
`endif
    return err;
  endfunction

  function automatic logic [31:0] refLoad(input int addr, input int size, input logic sgn);
    logic [31:0] v;
    if (size == 0) begin
      v = 32'(refMem[addr]);
      if (sgn && v >= 128) v = v - 32'd256;
    end else if (size == 1) begin
      v = 32'(refMem[addr]) * 256 + 32'(refMem[addr + 1]);
      if (sgn && v >= 32768) v = v - 32'd65536;
    end else begin
      v = {refMem[addr], refMem[addr + 1], refMem[addr + 2], refMem[addr + 3]};
    end
    return v;
  endfunction

  task automatic refStore(input int addr, input int size, input logic [31:0] data);
    int n;
    n = sizeBytes(size);
    for (int k = 0; k < n; k++) begin
      refMem[addr + k] = 8'((data >> (8 * (n - 1 - k))) & 32'hFF);
    end
  endtask

  // One full transaction from an IDLE-state start, sampled 1 time unit after each edge.
  task automatic applyStimulus(input int addr, input logic [31:0] wdata, input logic we,
                               input int size, input logic sgn, input int holdCycles,
                               output logic [31:0] obsData);
    logic        expErr;
    logic [31:0] expData;
    logic [31:0] heldData;
    logic        heldErr;
    int          edges;
    int          weCycles;
    expErr  = refError(addr, size);
    expData = (expErr || we) ? 32'd0 : refLoad(addr, size, sgn);
    checkOutput("reqReadyIdle", 32'(o_req_ready), 32'd1);
    i_req_valid  = 1'b1;
    i_req_addr   = 32'(addr);
    i_req_wdata  = wdata;
    i_req_we     = we;
    i_req_size   = 2'(size);
    i_req_signed = sgn;
    @(posedge i_clk); #1;
    i_req_valid  = 1'b0;
    i_req_addr   = $urandom;
    i_req_wdata  = $urandom;
    i_req_size   = 2'($urandom_range(0, 3));
    i_req_signed = 1'($urandom_range(0, 1));
    edges    = 1;
    weCycles = 0;
    while (!o_resp_valid && edges < 8) begin
      if (o_mem_writeEnable) weCycles++;
      @(posedge i_clk); #1;
      edges++;
    end
    checkOutput("respValid", 32'(o_resp_valid), 32'd1);
    checkOutput("latency", 32'(edges), expErr ? 32'd1 : 32'd2);
    checkOutput("weCycles", 32'(weCycles), (!expErr && we) ? 32'd1 : 32'd0);
    checkOutput("respErr", 32'(o_resp_err), 32'(expErr));
    checkOutput("respData", o_resp_rdata, expData);
    obsData  = o_resp_rdata;
    heldData = o_resp_rdata;
    heldErr  = o_resp_err;
    if (!expErr && we) refStore(addr, size, wdata);
    for (int c = 0; c < holdCycles; c++) begin
      @(posedge i_clk); #1;
      checkOutput("holdValid", 32'(o_resp_valid), 32'd1);
      checkOutput("holdData", o_resp_rdata, heldData);
      checkOutput("holdErr", 32'(o_resp_err), 32'(heldErr));
      checkOutput("holdReqReady", 32'(o_req_ready), 32'd0);
      checkOutput("holdWe", 32'(o_mem_writeEnable), 32'd0);
    end
    i_resp_ready = 1'b1;
    @(posedge i_clk); #1;
    i_resp_ready = 1'b0;
    checkOutput("validFall", 32'(o_resp_valid), 32'd0);
    checkOutput("readyBack", 32'(o_req_ready), 32'd1);
    if (addr <= 32764) begin
      checkOutput("memWord",
                  {simMem[addr], simMem[addr + 1], simMem[addr + 2], simMem[addr + 3]},
                  {refMem[addr], refMem[addr + 1], refMem[addr + 2], refMem[addr + 3]});
    end
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] got;
    logic [7:0]  oldByte;
    int          addr;
    int          size;
    logic        we;

    for (int i = 0; i < 32768; i++) begin
      simMem[i] = 8'($urandom);
      refMem[i] = simMem[i];
    end
    simMem[16'h2000] = 8'h80; refMem[16'h2000] = 8'h80;
    simMem[16'h2001] = 8'h12; refMem[16'h2001] = 8'h12;
    simMem[16'h2002] = 8'hFE; refMem[16'h2002] = 8'hFE;
    simMem[16'h2003] = 8'h34; refMem[16'h2003] = 8'h34;

    i_rst_n      = 1'b0;
    i_req_valid  = 1'b0;
    i_req_addr   = '0;
    i_req_wdata  = '0;
    i_req_we     = 1'b0;
    i_req_size   = '0;
    i_req_signed = 1'b0;
    i_resp_ready = 1'b0;

    #12;
    $display("[TB] checking reset state");
    checkOutput("rstReqReady", 32'(o_req_ready), 32'd0);
    checkOutput("rstRespValid", 32'(o_resp_valid), 32'd0);
    checkOutput("rstRespErr", 32'(o_resp_err), 32'd0);
    checkOutput("rstRespData", o_resp_rdata, 32'd0);
    checkOutput("rstMemAddr", o_mem_addr, 32'd0);
    checkOutput("rstMemWData", o_mem_wData, 32'd0);
    checkOutput("rstMemWe", 32'(o_mem_writeEnable), 32'd0);
    checkOutput("rstMemDsize", 32'(o_mem_dsize), 32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;

    $display("[TB] directed loads and stores");
    applyStimulus(32'h2000, 32'h0, 1'b0, 0, 1'b1, 0, got);
    checkOutput("byteSigned", got, 32'hFFFFFF80);
    applyStimulus(32'h2000, 32'h0, 1'b0, 0, 1'b0, 0, got);
    checkOutput("byteUnsigned", got, 32'h00000080);
    applyStimulus(32'h2002, 32'h0, 1'b0, 1, 1'b1, 0, got);
    checkOutput("halfSigned", got, 32'hFFFFFE34);
    applyStimulus(32'h2000, 32'h0, 1'b0, 3, 1'b0, 0, got);
    checkOutput("wordLoad", got, 32'h8012FE34);
    applyStimulus(32'h2001, 32'h000000AB, 1'b1, 0, 1'b0, 0, got);
    applyStimulus(32'h2000, 32'h0, 1'b0, 3, 1'b0, 0, got);
    checkOutput("wordAfterStore", got, 32'h80ABFE34);
    applyStimulus(32'h2002, 32'h0, 1'b0, 3, 1'b0, 0, got);
    applyStimulus(32'h2000, 32'h0, 1'b0, 2, 1'b0, 0, got);
    applyStimulus(32'h2001, 32'h0, 1'b1, 1, 1'b0, 0, got);
    applyStimulus(32'h2000, 32'h0, 1'b0, 1, 1'b0, 5, got);
    applyStimulus(32'h3FFC, 32'h0, 1'b0, 3, 1'b0, 0, got);
    applyStimulus(32'h4000, 32'h0, 1'b0, 3, 1'b0, 0, got);
    applyStimulus(32'h3FFF, 32'h0, 1'b0, 0, 1'b1, 0, got);

    $display("[TB] reset during a store access");
    oldByte = refMem[16'h2005];
    i_req_valid  = 1'b1;
    i_req_addr   = 32'h2005;
    i_req_wdata  = {24'h0, ~oldByte};
    i_req_we     = 1'b1;
    i_req_size   = 2'd0;
    i_req_signed = 1'b0;
    @(posedge i_clk); #1;
    i_req_valid = 1'b0;
    checkOutput("accessWe", 32'(o_mem_writeEnable), 32'd1);
    #2;
    i_rst_n = 1'b0;
    #1;
    checkOutput("asyncWeDrop", 32'(o_mem_writeEnable), 32'd0);
    checkOutput("asyncReqReady", 32'(o_req_ready), 32'd0);
    @(posedge i_clk); #1;
    checkOutput("memUnchanged", 32'(simMem[16'h2005]), 32'(oldByte));
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    checkOutput("respDiscarded", 32'(o_resp_valid), 32'd0);
    checkOutput("readyAfterRst", 32'(o_req_ready), 32'd1);

    $display("[TB] randomized traffic");
    for (int t = 0; t < 200; t++) begin
      size = $urandom_range(0, 3);
      addr = $urandom_range(0, 32764);
      if ($urandom_range(0, 3) != 0) addr = addr - (addr % sizeBytes(size));
      we = 1'($urandom_range(0, 1));
      applyStimulus(addr, $urandom, we, size, 1'($urandom_range(0, 1)),
                    $urandom_range(0, 3), got);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_access_unit.md
Name: dmem_access_unit

Overview:
- Pipeline-side master for the data memory port. Accepts one load/store request at a time over a valid/ready handshake and drives the memory's addr, wData, writeEnable and dsize signals.
- Loads: extracts and zero/sign-extends the returned byte, halfword or word. Stores: right-justifies write data the way the memory's write lanes expect.
- Checks alignment and dsize legality, then returns a registered response with an error flag.
- Sits between the MEM pipeline stage and the data memory.

Parameters:
DMEM_SIZE, 32768, memory size in bytes; used by the optional bounds check.

Ports:
clk  in  1  clock; all state updates on posedge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  unit can accept a request
req_addr  in  [0:31]  byte address, big-endian (lowest address = MSB byte)
req_wdata  in  [0:31]  store data, right-justified (byte in [24:31], half in [16:31])
req_we  in  1  1=store, 0=load
req_size  in  [0:1]  3=word, 1=halfword, 0=byte, 2=illegal
req_signed  in  1  loads only: 1=sign-extend, 0=zero-extend
resp_valid  out  1  response present
resp_ready  in  1  consumer accepts response
resp_rdata  out  [0:31]  extended load data; 0 for stores and errors
resp_err  out  1  request rejected (misaligned, illegal size, out of bounds)
mem_addr  out  [0:31]  to memory addr
mem_wData  out  [0:31]  to memory wData
mem_writeEnable  out  1  to memory writeEnable
mem_dsize  out  [0:1]  to memory dsize
mem_rData  in  [0:31]  from memory rData, combinational read of bytes addr..addr+3

Behaviour:
- FSM states: IDLE, ACCESS, RESP.
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - req_ready=0 while rst_n=0, then 1 in IDLE.
  - resp_valid=0, resp_err=0, resp_rdata=0.
  - mem_addr=0, mem_wData=0, mem_writeEnable=0, mem_dsize=0.
  - Reset during ACCESS drops mem_writeEnable immediately, so no write occurs at the next edge. A pending response is discarded.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready, latch addr, wdata, we, size and signed, then evaluate the error conditions below.
  - Error: misaligned (half with addr[31]=1; word with addr[30:31]!=0), or size==2.
  - On error, go directly to RESP with resp_err=1 and resp_rdata=0. Memory is never touched.
  - Otherwise go to ACCESS.
- ACCESS (exactly one cycle):
  - req_ready=0.
  - mem_addr, mem_dsize and mem_wData come from the latched fields; mem_wData = latched wdata unmodified.
  - mem_writeEnable = latched we; the write commits at the closing edge.
  - Load: capture and extend mem_rData at the closing edge.
    - Byte: [0:7], extended from bit 0.
    - Half: [0:15], extended from bit 0.
    - Word: [0:31], taken as-is.
  - Extension: replicate the top bit if req_signed, else fill with 0.
  - Next state: RESP.
- RESP:
  - resp_valid=1; resp_rdata and resp_err stay stable until resp_ready=1.
  - On resp_ready, go to IDLE; resp_valid falls next cycle.
  - req_ready=0 throughout RESP. There is no same-cycle accept; the minimum request-to-request interval is 3 cycles.
- Latency: accept at edge T; ACCESS during T..T+1; resp_valid high after edge T+1. Error responses arrive after edge T.
- mem_writeEnable is high only in ACCESS with a latched store. It is 0 in IDLE and RESP, and while in reset.
- mem_addr/mem_dsize hold their last values outside ACCESS; mem_writeEnable=0 makes them don't-care.

Optional Feature:
- Macro: DMEM_BOUNDS_CHECK_EN.
- Defined: a request with addr + bytes > DMEM_SIZE is treated as an error, where bytes = size+1, computed in 33 bits so it cannot wrap. Handling is identical to a misalignment error: straight to RESP, resp_err=1, no memory access.
- Undefined: no bounds check; the address is passed through unchanged.

Decomposition:
- Shared package holds:
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_BAD=2'b10, SZ_WORD=2'b11;
  - the FSM state typedef.
- One natural sub-module, load_extend: combinational rData + size + signed -> 32-bit result. It is reusable by the writeback stage.

Test Plan:
- Preload 0x2000..0x2003 = 80 12 FE 34. Load byte, signed, at 0x2000 -> resp_rdata=0xFFFFFF80, err=0. Same load unsigned -> 0x00000080.
- Load half, signed, at 0x2002 -> 0xFFFFFE34. Load word at 0x2000 -> 0x8012FE34. resp_valid rises 2 edges after accept.
- Store byte 0x000000AB at 0x2001, then load word 0x2000 -> 0x80ABFE34. mem_writeEnable is high for exactly one cycle.
- Misaligned word load at 0x2002, and size=2 at 0x2000 -> resp_err=1, rdata=0, mem_writeEnable never asserted, response after 1 edge.
- Hold resp_ready=0 for 5 cycles -> resp_valid and data stable, req_ready=0. Assert rst_n=0 mid-ACCESS of a store -> mem_writeEnable drops asynchronously and memory is unchanged.
- With DMEM_BOUNDS_CHECK_EN and DMEM_SIZE=16384: word load at 0x3FFC -> ok. Word load at 0x4000 -> resp_err=1.
